// File: rtl/leaf_pkt_pkg.sv
// rtl/leaf_pkt_pkg.sv - packet layout, destination entry and credit types shared across the leaf shell
package leaf_pkt_pkg;

    localparam int PKT_W     = 49;
    localparam int PAYLOAD_W = 32;
    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;
    localparam int CRED_W    = 8;

    localparam int PKT_VALID_BIT   = 48;
    localparam int PKT_LEAF_LSB    = 43;
    localparam int PKT_PORT_LSB    = 39;
    localparam int PKT_ADDR_LSB    = 32;
    localparam int PKT_PAYLOAD_LSB = 0;

    typedef logic [CRED_W-1:0] credit_t;

    typedef struct packed {
        logic              configured;
        logic [LEAF_W-1:0] dst_leaf;
        logic [PORT_W-1:0] dst_port;
    } dst_entry_t;

    function automatic logic [PKT_W-1:0] make_packet(input dst_entry_t e,
                                                     input logic [ADDR_W-1:0] a,
                                                     input logic [PAYLOAD_W-1:0] d);
        logic [PKT_W-1:0] p;
        p = '0;
        p[PKT_VALID_BIT]                  = 1'b1;
        p[PKT_LEAF_LSB +: LEAF_W]         = e.dst_leaf;
        p[PKT_PORT_LSB +: PORT_W]         = e.dst_port;
        p[PKT_ADDR_LSB +: ADDR_W]         = a;
        p[PKT_PAYLOAD_LSB +: PAYLOAD_W]   = d;
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter, pointer parks on the last granted requester
module rr_arbiter_n
    import leaf_pkt_pkg::*;
#(
    parameter int N = 6,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [IW-1:0] ptr;

    // Two passes: requesters above the pointer first, then wrap to the low end.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (en && !grant_vld && req[j] && (j > int'(ptr))) begin
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
                grant_vld = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (en && !grant_vld && req[j] && (j <= int'(ptr))) begin
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= IW'(N - 1);
        end else if (grant_vld) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/leaf_out_packetizer.sv
// rtl/leaf_out_packetizer.sv - tags user output words with destination/address under credit flow control
// LEAF_PKT_STATS_EN adds stat_sel/stat_cnt per-port sent-packet counters.
module leaf_out_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int PACKET_BITS   = PKT_W,
    parameter int PAYLOAD_BITS  = PAYLOAD_W,
    parameter int NUM_LEAF_BITS = LEAF_W,
    parameter int NUM_PORT_BITS = PORT_W,
    parameter int NUM_ADDR_BITS = ADDR_W,
    parameter int NUM_OUT_PORTS = 6,
    parameter int CREDIT_BITS   = CRED_W,
    parameter int INIT_CREDITS  = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    input  logic                                  cfg_we,
    input  logic [NUM_PORT_BITS-1:0]              cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
    input  logic                                  credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]              credit_upd_port,
    input  logic [CREDIT_BITS-1:0]                credit_upd_amount,
    input  logic                                  bft_ready,
    input  logic                                  resend,
    output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
    output logic                                  err_credit_ovf
`ifdef LEAF_PKT_STATS_EN
    ,
    input  logic [NUM_PORT_BITS-1:0]              stat_sel,
    output logic [31:0]                           stat_cnt
`endif
);

    localparam int IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

    dst_entry_t               dst_table  [NUM_OUT_PORTS];
    credit_t                  credit     [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr       [NUM_OUT_PORTS];
    logic [CREDIT_BITS:0]     credit_sum [NUM_OUT_PORTS];
    logic [PACKET_BITS-1:0]   dout_q;
    logic [PACKET_BITS-1:0]   sel_pkt;
    logic [PAYLOAD_BITS-1:0]  sel_payload;
    logic [NUM_OUT_PORTS-1:0] req;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_vld;
    logic                     out_free;
    logic                     arb_en;
    logic                     ovf_any;

    assign out_free = !dout_q[PKT_VALID_BIT] || bft_ready;
    assign arb_en   = out_free && !resend;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            req[i] = vld_user2interface[i] && dst_table[i].configured && (credit[i] != '0);
        end
    end

    rr_arbiter_n #(.N(NUM_OUT_PORTS)) u_arb (
        .clk       (clk),
        .rst       (reset),
        .req       (req),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // The accept pulse is combinational so the user sees it in the grant cycle.
    assign ack_interface2user      = reset ? '0 : grant;
    assign dout_leaf_interface2bft = resend ? '0 : dout_q;

    always_comb begin
        sel_payload = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) sel_payload = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    assign sel_pkt = make_packet(dst_table[grant_idx], addr[grant_idx], sel_payload);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) addr[i] <= '0;
        end else if (!resend) begin
            if (grant_vld) begin
                dout_q <= sel_pkt;
            end else if (out_free) begin
                dout_q <= '0;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (grant[i]) addr[i] <= addr[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) dst_table[i] <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (cfg_port == NUM_PORT_BITS'(i)) dst_table[i] <= '{1'b1, cfg_dst_leaf, cfg_dst_port};
            end
        end
    end

    // Grant and freespace update fold into one net change; the extra MSB catches saturation.
    always_comb begin
        ovf_any = 1'b0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum[i] = {1'b0, credit[i]} - {{CREDIT_BITS{1'b0}}, grant[i]};
            if (credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i))) begin
                credit_sum[i] = credit_sum[i] + {1'b0, credit_upd_amount};
            end
            if (credit_sum[i][CREDIT_BITS]) ovf_any = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) credit[i] <= CREDIT_BITS'(INIT_CREDITS);
            err_credit_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_sum[i][CREDIT_BITS] ? '1 : credit_sum[i][CREDIT_BITS-1:0];
            end
            if (ovf_any) err_credit_ovf <= 1'b1;
        end
    end

`ifdef LEAF_PKT_STATS_EN
    logic [31:0] pkt_cnt [NUM_OUT_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) pkt_cnt[i] <= '0;
            stat_cnt <= '0;
        end else begin
            stat_cnt <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (grant[i]) pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
                if (stat_sel == NUM_PORT_BITS'(i)) stat_cnt <= pkt_cnt[i];
            end
        end
    end
`endif

endmodule
